// File: rtl/cpu_sequencer_if.sv
// Instruction-fetch, decoder and data-memory signals between the sequencer (master) and its environment (slave).
// Fetch and data handshakes are request/ack pairs; requests are held until the matching ack.
interface cpu_sequencer_if #(
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int PC_WIDTH          = 10,
    parameter int SELECTOR_WIDTH    = 2
);
    logic [PC_WIDTH-1:0]          imem_addr;
    logic                         imem_req;
    logic                         imem_ack;
    logic [INSTRUCTION_WIDTH-1:0] imem_rdata;
    logic [INSTRUCTION_WIDTH-1:0] instr;
    logic                         dec_A_we;
    logic                         dec_RF_we;
    logic                         dec_MEM_we;
    logic [SELECTOR_WIDTH-1:0]    dec_selector;
    logic                         dmem_req;
    logic                         dmem_ack;
    logic                         A_we;
    logic                         RF_we;
    logic                         MEM_we;

    modport master (
        output imem_addr, imem_req, instr, dmem_req, A_we, RF_we, MEM_we,
        input  imem_ack, imem_rdata, dec_A_we, dec_RF_we, dec_MEM_we, dec_selector, dmem_ack
    );

    modport slave (
        input  imem_addr, imem_req, instr, dmem_req, A_we, RF_we, MEM_we,
        output imem_ack, imem_rdata, dec_A_we, dec_RF_we, dec_MEM_we, dec_selector, dmem_ack
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: 3 cycles per instruction plus fetch waits, plus MEM_WAIT and data waits.
// Stalls indefinitely on imem_ack / dmem_ack; run and halt only take effect at instruction boundaries.
module cpu_sequencer #(
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int PC_WIDTH          = 10,
    parameter int SELECTOR_WIDTH    = 2,
    parameter int COUNT_WIDTH       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   halt_req,
    cpu_sequencer_if.master        bus,
    output logic                   busy,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_WAIT,
        S_EXECUTE,
        S_HALTED
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [PC_WIDTH-1:0]          pc;
    logic [INSTRUCTION_WIDTH-1:0] ir;
    logic                         halt_pending;
    logic [COUNT_WIDTH-1:0]       retired_q;
    logic                         ir_load;
    logic                         retire;
    logic                         mem_access;
    logic                         halt_any;

    assign halt_any   = halt_pending | halt_req;
    // Memory-sourced accumulator loads wait on data memory just like stores.
    assign mem_access = bus.dec_MEM_we |
                        (bus.dec_A_we & (bus.dec_selector == SELECTOR_WIDTH'(1)));
    assign retired    = retired_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= '0;
            ir           <= '0;
            halt_pending <= 1'b0;
            retired_q    <= '0;
        end else begin
            state <= state_nxt;
            if (ir_load) begin
                ir <= bus.imem_rdata;
                pc <= pc + PC_WIDTH'(1);
            end
            if (retire) begin
                retired_q <= retired_q + COUNT_WIDTH'(1);
            end
            // In IDLE a halt request is acted on directly, so it is only latched mid-instruction.
            if (halt_req && (state != S_IDLE)) begin
                halt_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        ir_load       = 1'b0;
        retire        = 1'b0;
        busy          = 1'b0;
        halted        = 1'b0;
        bus.imem_addr = pc;
        bus.imem_req  = 1'b0;
        bus.instr     = ir;
        bus.dmem_req  = 1'b0;
        bus.A_we      = 1'b0;
        bus.RF_we     = 1'b0;
        bus.MEM_we    = 1'b0;

        case (state)
            S_IDLE: begin
                if (halt_any) begin
                    state_nxt = S_HALTED;
                end else if (run) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                busy         = 1'b1;
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    ir_load   = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                busy      = 1'b1;
                state_nxt = mem_access ? S_MEM_WAIT : S_EXECUTE;
            end
            S_MEM_WAIT: begin
                busy         = 1'b1;
                bus.dmem_req = 1'b1;
                bus.MEM_we   = bus.dec_MEM_we;
                if (bus.dmem_ack) begin
                    state_nxt = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                busy      = 1'b1;
                bus.A_we  = bus.dec_A_we;
                bus.RF_we = bus.dec_RF_we;
                retire    = 1'b1;
                if (halt_any) begin
                    state_nxt = S_HALTED;
                end else if (!run) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_HALTED: begin
                halted    = 1'b1;
                bus.instr = '0;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a tiny decoder model maps IR bits to write enables and selector.
module tb_cpu_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        halt_req;
    logic        busy;
    logic        halted;
    logic [15:0] retired;
    logic [15:0] imem [0:1023];

    cpu_sequencer_if #(.INSTRUCTION_WIDTH(16), .PC_WIDTH(10), .SELECTOR_WIDTH(2)) bus ();

    cpu_sequencer #(
        .INSTRUCTION_WIDTH(16),
        .PC_WIDTH(10),
        .SELECTOR_WIDTH(2),
        .COUNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .halt_req(halt_req),
        .bus(bus),
        .busy(busy),
        .halted(halted),
        .retired(retired)
    );

    // Decoder model: [15]=A_we, [14]=RF_we, [13]=MEM_we, [1:0]=operand selector.
    assign bus.dec_A_we     = bus.instr[15];
    assign bus.dec_RF_we    = bus.instr[14];
    assign bus.dec_MEM_we   = bus.instr[13];
    assign bus.dec_selector = bus.instr[1:0];
    assign bus.imem_rdata   = imem[bus.imem_addr];

    always #5 clk = ~clk;

    int total  = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] req_h, awe_h, rfwe_h, dreq_h, mwe_h, any_h;
        int          wait_cnt;
        bit          found;

        rst = 1'b1; run = 1'b0; halt_req = 1'b0;
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        for (int i = 0; i < 1024; i++) imem[i] = 16'h0000;
        imem[0] = 16'h8004;  // A_we, register source
        imem[1] = 16'h8008;  // A_we, register source
        imem[2] = 16'hC00C;  // A_we + RF_we
        imem[3] = 16'h8001;  // load from memory
        imem[4] = 16'h2000;  // store
        imem[5] = 16'hC001;  // load from memory + RF_we

        // Reset state
        step; step;
        chk("rst_imem_req", 32'(bus.imem_req), 0);
        chk("rst_dmem_req", 32'(bus.dmem_req), 0);
        chk("rst_busy",     32'(busy), 0);
        chk("rst_halted",   32'(halted), 0);
        chk("rst_retired",  32'(retired), 0);
        chk("rst_pc",       32'(bus.imem_addr), 0);
        chk("rst_instr",    32'(bus.instr), 0);
        chk("rst_strobes",  32'({bus.A_we, bus.RF_we, bus.MEM_we}), 0);

        // Three register-only instructions, fetch acked immediately
        rst = 1'b0; run = 1'b1; bus.imem_ack = 1'b1;
        req_h = '0; awe_h = '0; rfwe_h = '0;
        for (int c = 1; c <= 9; c++) begin
            step;
            req_h[c]  = bus.imem_req;
            awe_h[c]  = bus.A_we;
            rfwe_h[c] = bus.RF_we;
            if (c == 2) chk("t1_ir0", 32'(bus.instr), 'h8004);
            if (c == 5) chk("t1_ir1", 32'(bus.instr), 'h8008);
            if (c == 8) begin
                chk("t1_ir2", 32'(bus.instr), 'hC00C);
                run = 1'b0;
            end
        end
        chk("t1_imem_req_cycles", 32'(req_h), 'h092);
        chk("t1_A_we_cycles",     32'(awe_h), 'h248);
        chk("t1_RF_we_cycles",    32'(rfwe_h), 'h200);
        chk("t1_pc",              32'(bus.imem_addr), 3);
        step;
        chk("t1_retired", 32'(retired), 3);
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_req",  32'(bus.imem_req), 0);

        // Memory-sourced load, data ack on third MEM_WAIT cycle; run dropped in DECODE
        run = 1'b1; wait_cnt = 0;
        dreq_h = '0; awe_h = '0; mwe_h = '0;
        for (int c = 1; c <= 7; c++) begin
            step;
            dreq_h[c] = bus.dmem_req;
            awe_h[c]  = bus.A_we;
            mwe_h[c]  = bus.MEM_we;
            if (c == 2) run = 1'b0;
            bus.dmem_ack = bus.dmem_req && (wait_cnt == 2);
            if (bus.dmem_req) wait_cnt++;
        end
        chk("t2_dmem_req_cycles", 32'(dreq_h), 'h38);
        chk("t2_A_we_cycles",     32'(awe_h), 'h40);
        chk("t2_MEM_we_cycles",   32'(mwe_h), 0);
        chk("t2_retired",         32'(retired), 4);
        chk("t2_pc",              32'(bus.imem_addr), 4);
        chk("t2_idle_busy",       32'(busy), 0);

        // Store with data ack held high (also high outside MEM_WAIT)
        bus.dmem_ack = 1'b1; run = 1'b1;
        dreq_h = '0; mwe_h = '0; any_h = '0;
        for (int c = 1; c <= 5; c++) begin
            step;
            dreq_h[c] = bus.dmem_req;
            mwe_h[c]  = bus.MEM_we;
            any_h[c]  = bus.A_we | bus.RF_we;
            if (c == 1) run = 1'b0;
        end
        chk("t3_dmem_req_cycles", 32'(dreq_h), 'h08);
        chk("t3_MEM_we_cycles",   32'(mwe_h), 'h08);
        chk("t3_A_RF_we_cycles",  32'(any_h), 0);
        chk("t3_retired",         32'(retired), 5);
        chk("t3_idle_busy",       32'(busy), 0);
        bus.dmem_ack = 1'b0;

        // halt_req pulsed during MEM_WAIT
        run = 1'b1;
        step;
        chk("t4_fetch_addr", 32'(bus.imem_addr), 5);
        step;
        chk("t4_ir", 32'(bus.instr), 'hC001);
        step;
        chk("t4_mem_wait", 32'(bus.dmem_req), 1);
        halt_req = 1'b1;
        step;
        chk("t4_mem_wait2", 32'(bus.dmem_req), 1);
        chk("t4_not_halted_yet", 32'(halted), 0);
        halt_req = 1'b0; bus.dmem_ack = 1'b1;
        step;
        chk("t4_exec_strobes", 32'({bus.A_we, bus.RF_we}), 3);
        chk("t4_exec_busy", 32'(busy), 1);
        bus.dmem_ack = 1'b0;
        step;
        chk("t4_halted",      32'(halted), 1);
        chk("t4_halted_busy", 32'(busy), 0);
        chk("t4_halted_req",  32'(bus.imem_req), 0);
        chk("t4_retired",     32'(retired), 6);
        chk("t4_pc_held",     32'(bus.imem_addr), 6);
        chk("t4_instr_zero",  32'(bus.instr), 0);
        step; step;
        chk("t4_still_halted", 32'(halted), 1);
        chk("t4_still_no_req", 32'({bus.imem_req, bus.A_we, bus.RF_we, bus.MEM_we}), 0);

        // PC wrap after 1023 NOPs, run dropped in DECODE, resume at address 0
        rst = 1'b1; run = 1'b0;
        for (int i = 0; i < 6; i++) imem[i] = 16'h0000;
        imem[1023] = 16'h8000;
        step;
        rst = 1'b0;
        chk("t5_rst_halted",  32'(halted), 0);
        chk("t5_rst_retired", 32'(retired), 0);
        run = 1'b1; found = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            step;
            if (bus.imem_req && (bus.imem_addr == 10'd1023)) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_reach_1023", 32'(found), 1);
        chk("t5_retired_1023", 32'(retired), 1023);
        step;
        chk("t5_pc_wrap", 32'(bus.imem_addr), 0);
        chk("t5_ir_1023", 32'(bus.instr), 'h8000);
        run = 1'b0;
        step;
        chk("t5_exec_A_we", 32'(bus.A_we), 1);
        step;
        chk("t5_idle_busy", 32'(busy), 0);
        chk("t5_idle_req",  32'(bus.imem_req), 0);
        chk("t5_retired",   32'(retired), 1024);
        step;
        run = 1'b1;
        step;
        chk("t5_resume_req",  32'(bus.imem_req), 1);
        chk("t5_resume_addr", 32'(bus.imem_addr), 0);

        // Reset while a fetch is waiting; a late ack must be ignored
        step;
        bus.imem_ack = 1'b0;
        chk("t6_pc_after_fetch", 32'(bus.imem_addr), 1);
        step;
        chk("t6_nop_strobes", 32'({bus.A_we, bus.RF_we, bus.MEM_we}), 0);
        step; step;
        chk("t6_fetch_wait_req",  32'(bus.imem_req), 1);
        chk("t6_fetch_wait_addr", 32'(bus.imem_addr), 1);
        rst = 1'b1;
        step;
        chk("t6_rst_req",     32'(bus.imem_req), 0);
        chk("t6_rst_pc",      32'(bus.imem_addr), 0);
        chk("t6_rst_retired", 32'(retired), 0);
        chk("t6_rst_busy",    32'(busy), 0);
        rst = 1'b0; run = 1'b0; bus.imem_ack = 1'b1;
        step;
        chk("t6_late_ack_req",  32'(bus.imem_req), 0);
        chk("t6_late_ack_busy", 32'(busy), 0);
        chk("t6_late_ack_pc",   32'(bus.imem_addr), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control unit driving the instruction decoder and accumulator datapath.
- Fetches 16-bit instructions from instruction memory through a req/ack handshake and holds each one in an instruction register (IR) feeding the decoder.
- Waits on data memory when the decoded instruction touches memory.
- Converts the decoder's level write enables into single-cycle, state-gated write strobes for the accumulator, register file and data memory.

Parameters:
INSTRUCTION_WIDTH, 16, IR and instruction-memory data width
PC_WIDTH, 10, program counter / instruction address width
SELECTOR_WIDTH, 2, decoder operand-source selector width
COUNT_WIDTH, 16, retired-instruction counter width

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
run  in  1  level; 1 = execute program, 0 = stop at next instruction boundary
halt_req  in  1  single-cycle or level request to halt permanently
imem_addr  out  PC_WIDTH  instruction fetch address (= PC)
imem_req  out  1  fetch request, held until imem_ack
imem_ack  in  1  fetch complete, imem_rdata valid this cycle
imem_rdata  in  INSTRUCTION_WIDTH  fetched instruction
instr  out  INSTRUCTION_WIDTH  IR contents, drives decoder
dec_A_we  in  1  decoder accumulator write enable
dec_RF_we  in  1  decoder register-file write enable
dec_MEM_we  in  1  decoder memory write enable
dec_selector  in  SELECTOR_WIDTH  decoder operand source (01 = memory)
dmem_req  out  1  data-memory access request, held until dmem_ack
dmem_ack  in  1  data-memory access complete
A_we  out  1  gated accumulator write strobe
RF_we  out  1  gated register-file write strobe
MEM_we  out  1  gated data-memory write
busy  out  1  1 in any state except IDLE and HALTED
halted  out  1  1 in HALTED
retired  out  COUNT_WIDTH  count of completed EXECUTE cycles

Behaviour:
- Reset (synchronous, any state, including mid-handshake):
  - state=IDLE; PC=0; IR=0; halt_pending=0; retired=0.
  - All strobes and requests 0; busy=0; halted=0.
- States: IDLE, FETCH, DECODE, MEM_WAIT, EXECUTE, HALTED.
- IDLE:
  - run=1 -> FETCH next cycle.
  - halt_pending=1 or halt_req=1 -> HALTED, with priority over run.
- FETCH:
  - imem_req=1 and imem_addr=PC, held stable until ack.
  - On imem_ack: IR<=imem_rdata; PC<=PC+1, wrapping 2^PC_WIDTH-1 -> 0; -> DECODE.
  - No ack -> stay in FETCH, no timeout.
- DECODE:
  - One cycle; decoder settles from IR.
  - mem_access = dec_MEM_we | (dec_A_we & dec_selector==01).
  - mem_access -> MEM_WAIT, else -> EXECUTE.
- MEM_WAIT:
  - dmem_req=1 held until dmem_ack.
  - MEM_we=dec_MEM_we for every MEM_WAIT cycle; the store commits on the ack cycle.
  - On dmem_ack -> EXECUTE.
  - Memory holds read data stable from ack until the next dmem_req.
- EXECUTE:
  - One cycle; A_we=dec_A_we, RF_we=dec_RF_we; retired<=retired+1, wrapping.
  - Next state, in priority order:
    - halt_pending or halt_req -> HALTED.
    - run=0 -> IDLE.
    - otherwise -> FETCH.
- HALTED: terminal; every output 0 except halted=1 and PC/retired, which are held. Exit only by rst.
- A_we, RF_we and MEM_we are never asserted outside EXECUTE (A_we, RF_we) or MEM_WAIT (MEM_we). Decoder outputs in any other state are ignored.
- halt_pending:
  - Set by halt_req=1 in any non-IDLE state.
  - The current instruction always completes; halt never aborts a handshake.
- run deassertion mid-instruction: the instruction completes and the block returns to IDLE after EXECUTE. Re-raising run resumes at the current PC.
- Instruction latency:
  - 3 cycles (FETCH, DECODE, EXECUTE) with ack in the first FETCH cycle and no memory access.
  - +1 cycle per fetch wait cycle.
  - +1 cycle for MEM_WAIT, plus 1 per data wait cycle.
- imem_ack outside FETCH and dmem_ack outside MEM_WAIT are ignored.
- An instruction with no decoder write enables (NOP) passes through EXECUTE with no strobes and still increments retired.

Test Plan:
- Reset, run=1, imem_ack tied 1, three non-memory instructions -> imem_req high at cycles 1, 4, 7. IR loads each word. A_we pulses one cycle in each EXECUTE. Final PC=3, retired=3.
- Memory-sourced load (dec_A_we=1, dec_selector=01), dmem_ack delayed 2 cycles -> dmem_req high exactly 3 cycles. A_we one cycle after ack. MEM_we stays 0.
- Store (dec_MEM_we=1), dmem_ack immediate -> MEM_we=1 coincident with dmem_req for 1 cycle. A_we=0 and RF_we=0 throughout.
- halt_req pulsed during MEM_WAIT -> that instruction still reaches EXECUTE and retired increments. Next cycle HALTED: halted=1, imem_req stays 0 even with run=1.
- PC=1023, fetch acked -> PC wraps to 0. run dropped during DECODE -> IDLE after EXECUTE. Raising run again fetches address 0.
- rst asserted while imem_req is waiting for ack -> next cycle IDLE, imem_req=0, PC=0, retired=0. A late imem_ack is ignored.
